// File: rtl/spi_ip_pkg.sv
// Shared definitions for the SPI slave-side IP blocks: state encoding,
// width helper and default edge-gap limit.
package spi_ip_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } sckr_state_t;

  localparam int DEFAULT_MIN_EDGE_GAP = 3;

  // Bits needed to hold values 0..value-1 (never less than 1).
  function automatic int clogb2(input int value);
    int r;
    r = 1;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/spi_ip_sync.sv
// N-stage flip-flop synchronizer for a single asynchronous input, with a
// selectable reset level so idle-high lines do not glitch out of reset.
module spi_ip_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync <= {STAGES{RST_VAL}};
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/spi_ip_sck_recover.sv
// Slave-side SCK recovery: synchronizes SCK/SS_n, turns SCK edges into
// registered start/sample/shift strobes, counts bits and checks SCK speed.
module spi_ip_sck_recover
  import spi_ip_pkg::*;
#(
  parameter int PARAM_SYNC_STAGES  = 2,
  parameter int PARAM_DATA_WIDTH   = 8,
  parameter int PARAM_MIN_EDGE_GAP = DEFAULT_MIN_EDGE_GAP
) (
  input  logic                                sckr_clk_i,
  input  logic                                sckr_rst_i,
  input  logic                                sckr_enable_i,
  input  logic                                sckr_cpol_i,
  input  logic                                sckr_cpha_i,
  input  logic                                sckr_sck_i,
  input  logic                                sckr_ss_n_i,
  output logic                                sckr_start_o,
  output logic                                sckr_sample_o,
  output logic                                sckr_shift_o,
  output logic [clogb2(PARAM_DATA_WIDTH)-1:0] sckr_bit_cnt_o,
  output logic                                sckr_frame_done_o,
  output logic                                sckr_abort_o,
  output logic                                sckr_busy_o,
  output logic                                sckr_err_fast_o,
  output logic                                sckr_err_pol_o
);

  localparam int BIT_W = clogb2(PARAM_DATA_WIDTH);
  localparam int GAP_W = clogb2(PARAM_MIN_EDGE_GAP + 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(PARAM_DATA_WIDTH - 1);
  localparam logic [GAP_W-1:0] GAP_SAT  = GAP_W'(PARAM_MIN_EDGE_GAP);

  sckr_state_t r_state, w_state_nx;
  logic w_sck_s, w_ss_s;
  logic r_sck_d, r_ss_d;
  logic [PARAM_SYNC_STAGES-1:0] r_flush;
  logic r_armed;
  logic r_cpol, r_cpha, w_cpol_nx, w_cpha_nx;
  logic [BIT_W-1:0] r_bit_cnt, w_bit_cnt_nx;
  logic [GAP_W-1:0] r_gap, w_gap_nx;
  logic r_start, r_sample, r_shift, r_done, r_abort, r_err_fast, r_err_pol;
  logic w_start_nx, w_sample_nx, w_shift_nx, w_done_nx, w_abort_nx;
  logic w_err_fast_nx, w_err_pol_nx;
  logic w_sck_rise, w_sck_fall, w_sck_edge, w_ss_fall, w_ss_rise;
  logic w_leading, w_sample_ev;

  spi_ip_sync #(.STAGES(PARAM_SYNC_STAGES), .RST_VAL(1'b0)) u_sck_sync (
    .i_clk(sckr_clk_i), .i_rst(sckr_rst_i), .i_d(sckr_sck_i), .o_q(w_sck_s)
  );

  spi_ip_sync #(.STAGES(PARAM_SYNC_STAGES), .RST_VAL(1'b1)) u_ss_sync (
    .i_clk(sckr_clk_i), .i_rst(sckr_rst_i), .i_d(sckr_ss_n_i), .o_q(w_ss_s)
  );

  // SS_n falls only count once a genuine high level has reached the
  // synchronizer output after reset, so a low SS_n at release is ignored.
  assign w_sck_rise  = w_sck_s & ~r_sck_d;
  assign w_sck_fall  = ~w_sck_s & r_sck_d;
  assign w_sck_edge  = w_sck_rise | w_sck_fall;
  assign w_ss_fall   = ~w_ss_s & r_ss_d & r_armed;
  assign w_ss_rise   = w_ss_s & ~r_ss_d;
  assign w_leading   = r_cpol ? w_sck_fall : w_sck_rise;
  assign w_sample_ev = w_leading ^ r_cpha;

  always_ff @(posedge sckr_clk_i or posedge sckr_rst_i) begin
    if (sckr_rst_i) begin
      r_state    <= ST_IDLE;
      r_sck_d    <= 1'b0;
      r_ss_d     <= 1'b1;
      r_flush    <= '0;
      r_armed    <= 1'b0;
      r_cpol     <= 1'b0;
      r_cpha     <= 1'b0;
      r_bit_cnt  <= '0;
      r_gap      <= GAP_SAT;
      r_start    <= 1'b0;
      r_sample   <= 1'b0;
      r_shift    <= 1'b0;
      r_done     <= 1'b0;
      r_abort    <= 1'b0;
      r_err_fast <= 1'b0;
      r_err_pol  <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_sck_d    <= w_sck_s;
      r_ss_d     <= w_ss_s;
      r_flush    <= {r_flush[PARAM_SYNC_STAGES-2:0], 1'b1};
      r_armed    <= r_armed | (r_flush[PARAM_SYNC_STAGES-1] & w_ss_s);
      r_cpol     <= w_cpol_nx;
      r_cpha     <= w_cpha_nx;
      r_bit_cnt  <= w_bit_cnt_nx;
      r_gap      <= w_gap_nx;
      r_start    <= w_start_nx;
      r_sample   <= w_sample_nx;
      r_shift    <= w_shift_nx;
      r_done     <= w_done_nx;
      r_abort    <= w_abort_nx;
      r_err_fast <= w_err_fast_nx;
      r_err_pol  <= w_err_pol_nx;
    end
  end

  always_comb begin
    w_state_nx    = r_state;
    w_cpol_nx     = r_cpol;
    w_cpha_nx     = r_cpha;
    w_bit_cnt_nx  = r_bit_cnt;
    w_start_nx    = 1'b0;
    w_sample_nx   = 1'b0;
    w_shift_nx    = 1'b0;
    w_done_nx     = 1'b0;
    w_abort_nx    = 1'b0;
    w_err_fast_nx = r_err_fast;
    w_err_pol_nx  = r_err_pol;
    // Clocks since the last SCK edge, saturating; runs in every state.
    if (w_sck_edge)            w_gap_nx = '0;
    else if (r_gap == GAP_SAT) w_gap_nx = r_gap;
    else                       w_gap_nx = r_gap + 1'b1;

    if (!sckr_enable_i) begin
      w_state_nx    = ST_IDLE;
      w_bit_cnt_nx  = '0;
      w_err_fast_nx = 1'b0;
      w_err_pol_nx  = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_ss_fall) begin
            w_state_nx    = ST_ACTIVE;
            w_start_nx    = 1'b1;
            w_bit_cnt_nx  = '0;
            w_cpol_nx     = sckr_cpol_i;
            w_cpha_nx     = sckr_cpha_i;
            w_err_fast_nx = 1'b0;
            w_err_pol_nx  = (w_sck_s != sckr_cpol_i);
            w_gap_nx      = '0;
          end
        end
        ST_ACTIVE: begin
          if (w_ss_rise) begin
            w_state_nx   = ST_IDLE;
            w_abort_nx   = (r_bit_cnt != '0);
            w_bit_cnt_nx = '0;
          end else if (w_sck_edge) begin
            if (r_gap < GAP_SAT) w_err_fast_nx = 1'b1;
            if (w_sample_ev) begin
              w_sample_nx = 1'b1;
              if (r_bit_cnt == LAST_BIT) begin
                w_done_nx    = 1'b1;
                w_bit_cnt_nx = '0;
              end else begin
                w_bit_cnt_nx = r_bit_cnt + 1'b1;
              end
            end else begin
              w_shift_nx = 1'b1;
            end
          end
        end
        default: w_state_nx = ST_IDLE;
      endcase
    end
  end

  assign sckr_start_o      = r_start;
  assign sckr_sample_o     = r_sample;
  assign sckr_shift_o      = r_shift;
  assign sckr_bit_cnt_o    = r_bit_cnt;
  assign sckr_frame_done_o = r_done;
  assign sckr_abort_o      = r_abort;
  assign sckr_busy_o       = (r_state == ST_ACTIVE);
  assign sckr_err_fast_o   = r_err_fast;
  assign sckr_err_pol_o    = r_err_pol;

endmodule

// File: tb/tb_spi_ip_sck_recover.sv
// Bench for spi_ip_sck_recover: directed scenarios plus random frames,
// every cycle compared against a pin-history reference model.
module tb_spi_ip_sck_recover;

  localparam int SS  = 2;
  localparam int DW  = 8;
  localparam int MG  = 3;
  localparam int LAT = SS + 1;
  localparam int BW  = 3;
  localparam int EW  = 8 + BW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0, cpol = 1'b0, cpha = 1'b0, sck = 1'b0, ss_n = 1'b1;
  logic sckr_start_o, sckr_sample_o, sckr_shift_o, sckr_frame_done_o;
  logic sckr_abort_o, sckr_busy_o, sckr_err_fast_o, sckr_err_pol_o;
  logic [BW-1:0] sckr_bit_cnt_o;

  int n_chk = 0, n_err = 0;
  int c_start = 0, c_sample = 0, c_shift = 0, c_done = 0, c_abort = 0;
  int b_start, b_sample, b_shift, b_done, b_abort;
  int lat;

  // model state
  logic [EW-1:0] exp_q[$];
  logic sck_h[$];
  logic ss_h[$];
  int   n_real = 0, k = 0, last_ref = -1000, m_cnt = 0;
  logic m_act = 1'b0, m_cpol = 1'b0, m_cpha = 1'b0, m_ef = 1'b0, m_ep = 1'b0;

  spi_ip_sck_recover #(
    .PARAM_SYNC_STAGES(SS), .PARAM_DATA_WIDTH(DW), .PARAM_MIN_EDGE_GAP(MG)
  ) dut (
    .sckr_clk_i(clk), .sckr_rst_i(rst), .sckr_enable_i(en),
    .sckr_cpol_i(cpol), .sckr_cpha_i(cpha), .sckr_sck_i(sck), .sckr_ss_n_i(ss_n),
    .sckr_start_o(sckr_start_o), .sckr_sample_o(sckr_sample_o),
    .sckr_shift_o(sckr_shift_o), .sckr_bit_cnt_o(sckr_bit_cnt_o),
    .sckr_frame_done_o(sckr_frame_done_o), .sckr_abort_o(sckr_abort_o),
    .sckr_busy_o(sckr_busy_o), .sckr_err_fast_o(sckr_err_fast_o),
    .sckr_err_pol_o(sckr_err_pol_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: synchronized pins are the pin samples LAT-1 and LAT
  // clocks old; strobes follow directly from the protocol rules.
  always @(posedge clk) begin : ref_model
    logic sc, sp, qc, qp, e_start, e_samp, e_shift, e_done, e_abort, lead_ev;
    e_start = 0; e_samp = 0; e_shift = 0; e_done = 0; e_abort = 0;
    if (rst) begin
      sck_h.delete(); ss_h.delete();
      n_real = 0; m_act = 0; m_cnt = 0; m_cpol = 0; m_cpha = 0;
      m_ef = 0; m_ep = 0; last_ref = -1000;
      exp_q.push_back('0);
    end else begin
      sck_h.push_back(sck);
      ss_h.push_back(ss_n);
      if (sck_h.size() > LAT + 2) begin
        void'(sck_h.pop_front());
        void'(ss_h.pop_front());
      end
      if (n_real < 100) n_real++;
      sc = (sck_h.size() > LAT - 1) ? sck_h[sck_h.size() - LAT] : 1'b0;
      sp = (sck_h.size() > LAT) ? sck_h[sck_h.size() - 1 - LAT] : 1'b0;
      qc = (ss_h.size() > LAT - 1) ? ss_h[ss_h.size() - LAT] : 1'b1;
      qp = (ss_h.size() > LAT) ? ss_h[ss_h.size() - 1 - LAT] : 1'b1;
      if (!en) begin
        m_act = 0; m_cnt = 0; m_ef = 0; m_ep = 0;
      end else if (!m_act) begin
        if (qp && !qc && n_real > LAT) begin
          m_act = 1; e_start = 1; m_cnt = 0; m_cpol = cpol; m_cpha = cpha;
          m_ef = 0; m_ep = (sc != cpol); last_ref = k;
        end
      end else if (!qp && qc) begin
        m_act = 0; e_abort = (m_cnt != 0); m_cnt = 0;
      end else if (sc != sp) begin
        if (k - last_ref - 1 < MG) m_ef = 1;
        lead_ev = m_cpol ? !sc : sc;
        if (lead_ev != m_cpha) begin
          e_samp = 1;
          if (m_cnt == DW - 1) begin e_done = 1; m_cnt = 0; end
          else m_cnt++;
        end else begin
          e_shift = 1;
        end
      end
      if (sc != sp) last_ref = k;
      exp_q.push_back({e_start, e_samp, e_shift, e_done, e_abort, m_act, m_ef, m_ep, BW'(m_cnt)});
    end
    k++;
  end

  always @(negedge clk) begin : scoreboard
    logic [EW-1:0] e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("start",     sckr_start_o,      e[EW-1]);
      check("sample",    sckr_sample_o,     e[EW-2]);
      check("shift",     sckr_shift_o,      e[EW-3]);
      check("done",      sckr_frame_done_o, e[EW-4]);
      check("abort",     sckr_abort_o,      e[EW-5]);
      check("busy",      sckr_busy_o,       e[EW-6]);
      check("err_fast",  sckr_err_fast_o,   e[EW-7]);
      check("err_pol",   sckr_err_pol_o,    e[EW-8]);
      check("bit_cnt",   sckr_bit_cnt_o,    e[BW-1:0]);
      c_start  += int'(sckr_start_o);
      c_sample += int'(sckr_sample_o);
      c_shift  += int'(sckr_shift_o);
      c_done   += int'(sckr_frame_done_o);
      c_abort  += int'(sckr_abort_o);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulses(input int np, input int half);
    for (int i = 0; i < np; i++) begin
      sck = ~sck; cyc(half);
      sck = ~sck; cyc(half);
    end
  endtask

  task automatic frame_open(input logic pol, input logic pha, input int lead);
    cpol = pol; cpha = pha; sck = pol;
    cyc(6);
    ss_n = 1'b0;
    cyc(lead);
  endtask

  task automatic frame_close();
    cyc(4);
    ss_n = 1'b1;
    cyc(8);
  endtask

  task automatic snap();
    b_start = c_start; b_sample = c_sample; b_shift = c_shift;
    b_done = c_done; b_abort = c_abort;
  endtask

  initial begin
    cyc(2);
    check("rst_busy", sckr_busy_o, 0);
    check("rst_start", sckr_start_o, 0);
    #2 rst = 1'b0; en = 1'b1;
    cyc(8);

    // mode 0, 8 pulses, first-sample latency measured from the pin edge
    snap();
    frame_open(1'b0, 1'b0, 8);
    sck = 1'b1; lat = 0;
    do begin cyc(1); lat++; end while (!sckr_sample_o && lat < 10);
    check("t1_latency", lat, 3);
    cyc(8 - lat); sck = 1'b0; cyc(8);
    pulses(7, 8);
    frame_close();
    check("t1_start", c_start - b_start, 1);
    check("t1_sample", c_sample - b_sample, 8);
    check("t1_shift", c_shift - b_shift, 8);
    check("t1_done", c_done - b_done, 1);
    check("t1_abort", c_abort - b_abort, 0);
    check("t1_bitcnt", sckr_bit_cnt_o, 0);

    // mode 3, two back-to-back frames under one SS_n low
    snap();
    frame_open(1'b1, 1'b1, 8);
    pulses(16, 8);
    frame_close();
    check("t2_start", c_start - b_start, 1);
    check("t2_done", c_done - b_done, 2);
    check("t2_sample", c_sample - b_sample, 16);
    check("t2_shift", c_shift - b_shift, 16);

    // partial frame abort and busy release latency
    snap();
    frame_open(1'b0, 1'b0, 8);
    pulses(5, 8);
    cyc(4);
    check("t3_busy_pre", sckr_busy_o, 1);
    ss_n = 1'b1; lat = 0;
    do begin cyc(1); lat++; end while (sckr_busy_o && lat < 10);
    check("t3_busy_lat", lat, 3);
    cyc(8);
    check("t3_abort", c_abort - b_abort, 1);
    check("t3_sample", c_sample - b_sample, 5);
    check("t3_bitcnt", sckr_bit_cnt_o, 0);

    // SCK too fast: sticky through SS_n rise, cleared by next start
    frame_open(1'b0, 1'b0, 8);
    pulses(4, 2);
    cyc(4);
    check("t4_fast_set", sckr_err_fast_o, 1);
    ss_n = 1'b1; cyc(8);
    check("t4_fast_hold", sckr_err_fast_o, 1);
    frame_open(1'b0, 1'b0, 8);
    check("t4_fast_clr", sckr_err_fast_o, 0);
    pulses(8, 8);
    frame_close();

    // CPOL mismatch at frame start
    snap();
    cpol = 1'b1; cpha = 1'b0; sck = 1'b0;
    cyc(6); ss_n = 1'b0; cyc(8);
    check("t5_err_pol", sckr_err_pol_o, 1);
    check("t5_start", c_start - b_start, 1);
    pulses(8, 8);
    frame_close();

    // enable dropped mid-frame
    frame_open(1'b0, 1'b0, 8);
    pulses(3, 8);
    snap();
    en = 1'b0; cyc(1);
    check("t6_en_busy", sckr_busy_o, 0);
    cyc(4); en = 1'b1;
    pulses(3, 8);
    check("t6_en_abort", c_abort - b_abort, 0);
    check("t6_en_idle", sckr_busy_o, 0);
    ss_n = 1'b1; cyc(8);

    // async reset mid-frame, SS_n held low across release
    frame_open(1'b1, 1'b0, 8);
    pulses(3, 8);
    #2 rst = 1'b1;
    cyc(1);
    check("t6_rst_busy", sckr_busy_o, 0);
    cyc(2);
    #2 rst = 1'b0;
    snap();
    pulses(4, 8);
    cyc(10);
    check("t6_no_start", c_start - b_start, 0);
    check("t6_rst_idle", sckr_busy_o, 0);
    ss_n = 1'b1; cyc(8);
    ss_n = 1'b0; cyc(8);
    check("t6_fresh_start", c_start - b_start, 1);
    check("t6_fresh_busy", sckr_busy_o, 1);
    ss_n = 1'b1; cyc(8);

    // random frames, including coincident SS_n/SCK changes
    for (int f = 0; f < 16; f++) begin
      logic pol, pha;
      pol = 1'($urandom_range(0, 1));
      pha = 1'($urandom_range(0, 1));
      cpol = pol; cpha = pha;
      sck = ($urandom_range(0, 3) == 0) ? ~pol : pol;
      cyc(6);
      if ($urandom_range(0, 3) == 0) sck = ~sck;
      ss_n = 1'b0;
      cyc($urandom_range(2, 8));
      pulses($urandom_range(1, 20), $urandom_range(2, 9));
      if ($urandom_range(0, 4) == 0) begin
        en = 1'b0; cyc(3); en = 1'b1;
      end
      cyc($urandom_range(0, 6));
      if ($urandom_range(0, 3) == 0) sck = ~sck;
      ss_n = 1'b1;
      cyc($urandom_range(4, 10));
    end

    cyc(5);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
